// File: rtl/sysctrl_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the sysctrl register slave.
// Optional watchdog enabled by defining SYSCTRL_ARB_WDOG_EN.
module sysctrl_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   req0, req1;
  logic   busy;
  logic   own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic   wdog_fire;

  // Handshake: a request is cyc&stb held until ack/err; one classic beat per grant,
  // the owner's ack/err is combinational from the slave, the non-owner simply stalls.
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign busy = (state_q == ST_BUSY);

  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign own_we  = owner_q ? m1_we_i  : m0_we_i;
  assign own_adr = owner_q ? m1_adr_i : m0_adr_i;
  assign own_dat = owner_q ? m1_dat_i : m0_dat_i;
  assign own_sel = owner_q ? m1_sel_i : m0_sel_i;

`ifdef SYSCTRL_ARB_WDOG_EN
  localparam logic [7:0] WDOG_TERM = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wdog_q, wdog_d;

  // Cleared throughout IDLE so every BUSY period starts counting from zero.
  always_comb begin
    wdog_d = wdog_q;
    if (!busy)         wdog_d = 8'd0;
    else if (!s_ack_i) wdog_d = wdog_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wdog_q <= 8'd0;
    else         wdog_q <= wdog_d;
  end

  // A real ack in the terminal cycle takes precedence over the timeout.
  assign wdog_fire = busy & (wdog_q == WDOG_TERM) & ~s_ack_i;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign wdog_fire      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_BUSY;
          owner_d = (req0 && req1) ? ~last_q : req1;
          last_d  = owner_d;
        end
      end
      ST_BUSY: begin
        if (s_ack_i || !own_cyc || wdog_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_sel_o  = 4'd0;
    grant_o  = 2'b00;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    if (busy) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_cyc & own_stb;
      s_we_o   = own_we;
      s_adr_o  = own_adr;
      s_dat_o  = own_dat;
      s_sel_o  = own_sel;
      grant_o  = owner_q ? 2'b10 : 2'b01;
      m0_ack_o = ~owner_q & s_ack_i;
      m1_ack_o =  owner_q & s_ack_i;
      m0_err_o = ~owner_q & wdog_fire;
      m1_err_o =  owner_q & wdog_fire;
      if (wdog_fire) begin
        if (owner_q) m1_dat_o = 32'hFFFF_FFFF;
        else         m0_dat_o = 32'hFFFF_FFFF;
      end
    end
  end

endmodule

// File: tb/tb_sysctrl_wb_arbiter.sv
// Directed bench for sysctrl_wb_arbiter with a registered-ack register slave model.
// Watchdog expectations follow SYSCTRL_ARB_WDOG_EN.
module tb_sysctrl_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sysctrl_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  // Slave model: registered ack one cycle after strobe, registered read data.
  logic [31:0] mem [0:3];
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        slave_ack_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      if (s_cyc_o && s_stb_o && !ack_q && slave_ack_en) begin
        ack_q   <= 1'b1;
        rdata_q <= mem[s_adr_o[3:2]];
        if (s_we_o) mem[s_adr_o[3:2]] <= s_dat_o;
      end
    end
  end

  assign s_ack_i = ack_q;
  assign s_dat_i = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m0(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_adr_i = a; m0_dat_i = d; m0_sel_i = 4'hF;
  endtask

  task automatic set_m1(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_adr_i = a; m1_dat_i = d; m1_sel_i = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    logic        err_seen;
    logic        busy_all;

    for (int i = 0; i < 4; i++) mem[i] = 32'd0;
    slave_ack_en = 1'b1;
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_s_stb", s_stb_o, 1'b0);
    chk("rst_acks", {m1_ack_o, m0_ack_o}, 2'b00);
    chk("rst_errs", {m1_err_o, m0_err_o}, 2'b00);
    resetn = 1'b1;
    tick();

    // Tie after reset: m0 first, m1 after the idle cycle, m1 ack at N+5
    set_m0(1'b1, 1'b1, 32'h2F00_0004, 32'h0000_0003);
    set_m1(1'b1, 1'b1, 32'h2F00_0008, 32'h0000_00A5);
    tick();
    chk("tie_grant_m0", grant_o, 2'b01);
    chk("tie_s_adr_m0", s_adr_o, 32'h2F00_0004);
    chk("tie_s_dat_m0", s_dat_o, 32'h0000_0003);
    chk("tie_s_we_m0", s_we_o, 1'b1);
    chk("tie_m1_stall", m1_ack_o, 1'b0);
    tick();
    chk("tie_m0_ack", m0_ack_o, 1'b1);
    chk("tie_m1_noack", m1_ack_o, 1'b0);
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("tie_idle_grant", grant_o, 2'b00);
    tick();
    chk("tie_grant_m1", grant_o, 2'b10);
    chk("tie_s_adr_m1", s_adr_o, 32'h2F00_0008);
    tick();
    chk("tie_m1_ack_n5", m1_ack_o, 1'b1);
    chk("tie_m0_noack", m0_ack_o, 1'b0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("tie_end_idle", grant_o, 2'b00);

    // Fairness: both hold requests for six transactions
    set_m0(1'b1, 1'b0, 32'h2F00_0004, 32'd0);
    set_m1(1'b1, 1'b0, 32'h2F00_0008, 32'd0);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'h0000_0003 : 32'h0000_00A5;
      tick();
      chk("fair_grant", grant_o, exp_g);
      chk("fair_early_ack", {m1_ack_o, m0_ack_o}, 2'b00);
      tick();
      chk("fair_acks", {m1_ack_o, m0_ack_o}, exp_g);
      chk("fair_rdata", (i % 2 == 0) ? m0_dat_o : m1_dat_o, exp_d);
      tick();
      chk("fair_idle", grant_o, 2'b00);
    end
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    // Single read by m0
    set_m0(1'b1, 1'b0, 32'h2F00_0004, 32'd0);
    tick();
    chk("rd_grant_n1", grant_o, 2'b01);
    chk("rd_s_we", s_we_o, 1'b0);
    chk("rd_s_sel", s_sel_o, 4'hF);
    tick();
    chk("rd_ack_n2", m0_ack_o, 1'b1);
    chk("rd_data", m0_dat_o, 32'h0000_0003);
    chk("rd_m1_dat", m1_dat_o, 32'h0000_0003);
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("rd_grant_n3", grant_o, 2'b00);
    chk("rd_ack_n3", m0_ack_o, 1'b0);

    // Abort: m1 drops cyc in its first BUSY cycle
    set_m1(1'b1, 1'b0, 32'h2F00_0008, 32'd0);
    tick();
    chk("ab_grant", grant_o, 2'b10);
    chk("ab_s_cyc_before", s_cyc_o, 1'b1);
    m1_cyc_i = 1'b0;
    #1;
    chk("ab_s_cyc_drop", s_cyc_o, 1'b0);
    chk("ab_s_stb_drop", s_stb_o, 1'b0);
    m1_stb_i = 1'b0;
    tick();
    chk("ab_idle_n2", grant_o, 2'b00);
    chk("ab_no_ack", m1_ack_o, 1'b0);

    // Watchdog: slave never acks
    slave_ack_en = 1'b0;
    set_m0(1'b1, 1'b0, 32'h2F00_0004, 32'd0);
`ifdef SYSCTRL_ARB_WDOG_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("wd_grant", grant_o, 2'b01);
      if (c < 4) begin
        chk("wd_err_early", m0_err_o, 1'b0);
      end else begin
        chk("wd_err_pulse", m0_err_o, 1'b1);
        chk("wd_err_data", m0_dat_o, 32'hFFFF_FFFF);
        chk("wd_m1_err", m1_err_o, 1'b0);
      end
    end
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("wd_idle", grant_o, 2'b00);
    chk("wd_err_cleared", m0_err_o, 1'b0);
`else
    err_seen = 1'b0;
    busy_all = 1'b1;
    repeat (110) begin
      tick();
      if (m0_err_o || m1_err_o) err_seen = 1'b1;
      if (grant_o !== 2'b01) busy_all = 1'b0;
    end
    chk("nowd_busy_held", busy_all, 1'b1);
    chk("nowd_no_err", err_seen, 1'b0);
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("nowd_abort_idle", grant_o, 2'b00);
`endif
    slave_ack_en = 1'b1;
    set_m0(1'b1, 1'b0, 32'h2F00_0004, 32'd0);
    tick();
    chk("post_wd_grant", grant_o, 2'b01);
    tick();
    chk("post_wd_ack", m0_ack_o, 1'b1);
    chk("post_wd_data", m0_dat_o, 32'h0000_0003);
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    // Async reset mid-transaction, then m0 wins the first tie
    set_m1(1'b1, 1'b0, 32'h2F00_0008, 32'd0);
    tick();
    chk("ar_busy", grant_o, 2'b10);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_grant_async", grant_o, 2'b00);
    chk("ar_stb_async", s_stb_o, 1'b0);
    chk("ar_cyc_async", s_cyc_o, 1'b0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    resetn = 1'b1;
    set_m0(1'b1, 1'b0, 32'h2F00_0004, 32'd0);
    set_m1(1'b1, 1'b0, 32'h2F00_0008, 32'd0);
    tick();
    chk("ar_tie_m0", grant_o, 2'b01);
    tick();
    chk("ar_tie_m0_ack", m0_ack_o, 1'b1);
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("ar_tie_idle", grant_o, 2'b00);
    tick();
    chk("ar_tie_m1", grant_o, 2'b10);
    tick();
    chk("ar_tie_m1_ack", m1_ack_o, 1'b1);
    chk("ar_tie_m1_data", m1_dat_o, 32'h0000_00A5);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
